// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, data and memory-side handshake signals for mem_arbiter.
// The slave modport is the arbiter's view; master is the requesters/memory.
interface mem_arbiter_if #(
   parameter int unsigned WIDTH = 32
);
   logic             if_req;
   logic [WIDTH-1:0] if_addr;
   logic [WIDTH-1:0] if_rdata;
   logic             if_done;
   logic             d_req;
   logic             d_we;
   logic [WIDTH-1:0] d_addr;
   logic [WIDTH-1:0] d_wdata;
   logic [WIDTH-1:0] d_rdata;
   logic             d_done;
   logic             mem_req;
   logic             mem_we;
   logic [WIDTH-1:0] mem_addr;
   logic [WIDTH-1:0] mem_wdata;
   logic [WIDTH-1:0] mem_rdata;
   logic             mem_ready;
   logic             busy;
   logic             err;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
      output if_rdata, if_done, d_rdata, d_done, mem_req, mem_we, mem_addr, mem_wdata,
             busy, err
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
      input  if_rdata, if_done, d_rdata, d_done, mem_req, mem_we, mem_addr, mem_wdata,
             busy, err
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch
// and load/store requesters, with a per-access ready timeout.
module mem_arbiter #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {StIdle, StIfAcc, StDAcc, StResp} state_e;

   localparam int unsigned CntW = $clog2(TIMEOUT + 1);
   localparam logic [CntW-1:0] WaitLast = CntW'(TIMEOUT - 1);

   state_e           state_q;
   logic             last_gnt_q;  // 0 = fetch, 1 = data
   logic [CntW-1:0]  wait_q;
   logic             mem_req_q;
   logic             mem_we_q;
   logic [WIDTH-1:0] mem_addr_q;
   logic [WIDTH-1:0] mem_wdata_q;
   logic [WIDTH-1:0] if_rdata_q;
   logic [WIDTH-1:0] d_rdata_q;
   logic             if_done_q;
   logic             d_done_q;
   logic             err_q;

   logic grant_if;
   logic grant_d;

   // On a tie the requester that did not win last time gets the grant.
   always_comb begin
      grant_if = bus.if_req && (!bus.d_req || last_gnt_q);
      grant_d  = bus.d_req && !grant_if;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         last_gnt_q  <= 1'b0;
         wait_q      <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
         if_done_q   <= 1'b0;
         d_done_q    <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         if_done_q <= 1'b0;
         d_done_q  <= 1'b0;
         err_q     <= 1'b0;
         case (state_q)
            StIdle: begin
               if (grant_if) begin
                  state_q     <= StIfAcc;
                  last_gnt_q  <= 1'b0;
                  wait_q      <= '0;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= 1'b0;
                  mem_addr_q  <= bus.if_addr;
                  mem_wdata_q <= '0;
               end else if (grant_d) begin
                  state_q     <= StDAcc;
                  last_gnt_q  <= 1'b1;
                  wait_q      <= '0;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= bus.d_we;
                  mem_addr_q  <= bus.d_addr;
                  mem_wdata_q <= bus.d_wdata;
               end
            end
            StIfAcc, StDAcc: begin
               if (bus.mem_ready) begin
                  state_q   <= StResp;
                  mem_req_q <= 1'b0;
                  if (state_q == StIfAcc) begin
                     if_rdata_q <= bus.mem_rdata;
                     if_done_q  <= 1'b1;
                  end else begin
                     if (!mem_we_q) d_rdata_q <= bus.mem_rdata;
                     d_done_q <= 1'b1;
                  end
               end else if (wait_q == WaitLast) begin
                  // Timeout clears the serviced result register, stores included.
                  state_q   <= StResp;
                  mem_req_q <= 1'b0;
                  err_q     <= 1'b1;
                  if (state_q == StIfAcc) begin
                     if_rdata_q <= '0;
                     if_done_q  <= 1'b1;
                  end else begin
                     d_rdata_q <= '0;
                     d_done_q  <= 1'b1;
                  end
               end else begin
                  wait_q <= wait_q + CntW'(1);
               end
            end
            StResp: state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.if_done   = if_done_q;
   assign bus.d_done    = d_done_q;
   assign bus.err       = err_q;
   assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; inputs change and outputs are
// sampled on the falling clock edge.
module tb_mem_arbiter;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   mem_arbiter_if #(.WIDTH(32)) bus ();

   mem_arbiter #(.WIDTH(32), .TIMEOUT(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      checks++;
      if (bus.mem_req !== 1'b0) begin
         errors++; $display("FAIL reset_mem_req got=%b exp=0", bus.mem_req);
      end
      checks++;
      if ({bus.if_done, bus.d_done, bus.err} !== 3'b000) begin
         errors++; $display("FAIL reset_pulses got=%b exp=000", {bus.if_done, bus.d_done, bus.err});
      end
      checks++;
      if ({bus.if_rdata, bus.d_rdata} !== 64'h0) begin
         errors++; $display("FAIL reset_rdata got=%h exp=0", {bus.if_rdata, bus.d_rdata});
      end
      rst = 1'b1;
   endtask

   task automatic test_lone_fetch();
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h40;
      @(negedge clk);
      checks++;
      if ({bus.mem_req, bus.mem_we, bus.busy} !== 3'b101) begin
         errors++; $display("FAIL fetch_cmd got=%b exp=101", {bus.mem_req, bus.mem_we, bus.busy});
      end
      checks++;
      if (bus.mem_addr !== 32'h40) begin
         errors++; $display("FAIL fetch_addr got=%h exp=00000040", bus.mem_addr);
      end
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'h0050_0093;
      @(negedge clk);
      checks++;
      if ({bus.if_done, bus.d_done, bus.err, bus.mem_req} !== 4'b1000) begin
         errors++;
         $display("FAIL fetch_done got=%b exp=1000", {bus.if_done, bus.d_done, bus.err, bus.mem_req});
      end
      checks++;
      if (bus.if_rdata !== 32'h0050_0093) begin
         errors++; $display("FAIL fetch_rdata got=%h exp=00500093", bus.if_rdata);
      end
      bus.if_req    = 1'b0;
      bus.mem_ready = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.if_done, bus.busy} !== 2'b00) begin
         errors++; $display("FAIL fetch_idle got=%b exp=00", {bus.if_done, bus.busy});
      end
   endtask

   task automatic test_tie_after_reset();
      rst = 1'b0;
      @(negedge clk);
      rst         = 1'b1;
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h80;
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b1;
      bus.d_addr  = 32'h100;
      bus.d_wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      checks++;
      if ({bus.mem_req, bus.mem_we} !== 2'b11 || bus.mem_addr !== 32'h100 ||
          bus.mem_wdata !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL tie_store_cmd got=%b/%h/%h exp=11/00000100/deadbeef",
                  {bus.mem_req, bus.mem_we}, bus.mem_addr, bus.mem_wdata);
      end
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'hCAFE_F00D;
      @(negedge clk);
      checks++;
      if ({bus.d_done, bus.if_done, bus.err} !== 3'b100) begin
         errors++;
         $display("FAIL tie_store_done got=%b exp=100", {bus.d_done, bus.if_done, bus.err});
      end
      checks++;
      if (bus.d_rdata !== 32'h0) begin
         errors++; $display("FAIL tie_store_rdata got=%h exp=00000000", bus.d_rdata);
      end
      bus.d_req     = 1'b0;
      bus.mem_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL tie_idle got=%b exp=0", bus.busy); end
      @(negedge clk);
      checks++;
      if ({bus.mem_req, bus.mem_we} !== 2'b10 || bus.mem_addr !== 32'h80) begin
         errors++;
         $display("FAIL tie_fetch_cmd got=%b/%h exp=10/00000080", {bus.mem_req, bus.mem_we},
                  bus.mem_addr);
      end
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'h1111_1111;
      @(negedge clk);
      checks++;
      if (bus.if_done !== 1'b1 || bus.if_rdata !== 32'h1111_1111 || bus.d_rdata !== 32'h0) begin
         errors++;
         $display("FAIL tie_fetch_done got=%b/%h/%h exp=1/11111111/00000000", bus.if_done,
                  bus.if_rdata, bus.d_rdata);
      end
      bus.if_req    = 1'b0;
      bus.mem_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_sustained_ties();
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h300;
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b0;
      bus.d_addr  = 32'h200;
      for (int i = 0; i < 4; i++) begin
         logic [31:0] exp_addr;
         exp_addr = (i % 2 == 0) ? 32'h200 : 32'h300;
         @(negedge clk);
         checks++;
         if (bus.mem_req !== 1'b1 || bus.mem_addr !== exp_addr) begin
            errors++;
            $display("FAIL ties_grant%0d got=%b/%h exp=1/%h", i, bus.mem_req, bus.mem_addr,
                     exp_addr);
         end
         bus.mem_ready = 1'b1;
         bus.mem_rdata = 32'hA0 + 32'(i);
         @(negedge clk);
         checks++;
         if ({bus.d_done, bus.if_done} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL ties_done%0d got=%b exp=%b", i, {bus.d_done, bus.if_done},
                     (i % 2 == 0) ? 2'b10 : 2'b01);
         end
         bus.mem_ready = 1'b0;
         if (i == 3) begin
            bus.if_req = 1'b0;
            bus.d_req  = 1'b0;
         end
         @(negedge clk);
      end
      checks++;
      if (bus.d_rdata !== 32'hA2 || bus.if_rdata !== 32'hA3 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL ties_final got=%h/%h/%b exp=000000a2/000000a3/0", bus.d_rdata,
                  bus.if_rdata, bus.busy);
      end
   endtask

   task automatic test_timeout();
      int high_cycles;
      high_cycles  = 0;
      bus.d_req    = 1'b1;
      bus.d_we     = 1'b0;
      bus.d_addr   = 32'h400;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         if (bus.mem_req === 1'b1) high_cycles++;
      end
      checks++;
      if (high_cycles != 16) begin
         errors++; $display("FAIL timeout_req_cycles got=%0d exp=16", high_cycles);
      end
      @(negedge clk);
      checks++;
      if ({bus.mem_req, bus.d_done, bus.err} !== 3'b011) begin
         errors++; $display("FAIL timeout_done got=%b exp=011", {bus.mem_req, bus.d_done, bus.err});
      end
      checks++;
      if (bus.d_rdata !== 32'h0) begin
         errors++; $display("FAIL timeout_rdata got=%h exp=00000000", bus.d_rdata);
      end
      bus.d_req = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.d_done, bus.err, bus.busy} !== 3'b000) begin
         errors++; $display("FAIL timeout_after got=%b exp=000", {bus.d_done, bus.err, bus.busy});
      end
   endtask

   task automatic test_ready_at_limit();
      bus.d_req  = 1'b1;
      bus.d_we   = 1'b0;
      bus.d_addr = 32'h500;
      for (int k = 0; k < 15; k++) @(negedge clk);
      @(negedge clk);
      checks++;
      if (bus.mem_req !== 1'b1) begin
         errors++; $display("FAIL limit_req_held got=%b exp=1", bus.mem_req);
      end
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'h1234;
      @(negedge clk);
      checks++;
      if ({bus.d_done, bus.err} !== 2'b10 || bus.d_rdata !== 32'h1234) begin
         errors++;
         $display("FAIL limit_done got=%b/%h exp=10/00001234", {bus.d_done, bus.err}, bus.d_rdata);
      end
      bus.d_req     = 1'b0;
      bus.mem_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_access();
      int done_seen;
      done_seen  = 0;
      bus.d_req  = 1'b1;
      bus.d_we   = 1'b0;
      bus.d_addr = 32'h600;
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.mem_req} !== 2'b11) begin
         errors++; $display("FAIL midrst_acc got=%b exp=11", {bus.busy, bus.mem_req});
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({bus.busy, bus.mem_req} !== 2'b00 || bus.d_rdata !== 32'h0) begin
         errors++;
         $display("FAIL midrst_async got=%b/%h exp=00/00000000", {bus.busy, bus.mem_req},
                  bus.d_rdata);
      end
      bus.d_req = 1'b0;
      @(negedge clk);
      if (bus.d_done === 1'b1) done_seen++;
      rst         = 1'b1;
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h700;
      @(negedge clk);
      if (bus.d_done === 1'b1) done_seen++;
      checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h700) begin
         errors++;
         $display("FAIL midrst_first_grant got=%b/%h exp=1/00000700", bus.mem_req, bus.mem_addr);
      end
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'h7777;
      @(negedge clk);
      if (bus.d_done === 1'b1) done_seen++;
      checks++;
      if (bus.if_done !== 1'b1 || bus.if_rdata !== 32'h7777) begin
         errors++;
         $display("FAIL midrst_fetch got=%b/%h exp=1/00007777", bus.if_done, bus.if_rdata);
      end
      bus.if_req    = 1'b0;
      bus.mem_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (done_seen != 0 || bus.busy !== 1'b0) begin
         errors++; $display("FAIL midrst_no_done got=%0d/%b exp=0/0", done_seen, bus.busy);
      end
   endtask

   initial begin
      errors        = 0;
      checks        = 0;
      rst           = 1'b0;
      bus.if_req    = 1'b0;
      bus.if_addr   = '0;
      bus.d_req     = 1'b0;
      bus.d_we      = 1'b0;
      bus.d_addr    = '0;
      bus.d_wdata   = '0;
      bus.mem_rdata = '0;
      bus.mem_ready = 1'b0;
      test_reset();
      test_lone_fetch();
      test_tie_after_reset();
      test_sustained_ties();
      test_timeout();
      test_ready_at_limit();
      test_reset_mid_access();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32: address and data width.
REQ-002 SHALL have parameter TIMEOUT, default 16: maximum cycles an access waits for mem_ready.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port if_req, input, 1: instruction-fetch request; held high until if_done.
REQ-006 SHALL have port if_addr, input, WIDTH: fetch address; sampled at grant.
REQ-007 SHALL have port if_rdata, output, WIDTH: fetched word.
REQ-008 SHALL have port if_done, output, 1: one-cycle fetch-completion pulse.
REQ-009 SHALL have port d_req, input, 1: load/store request; held high until d_done.
REQ-010 SHALL have port d_we, input, 1: 1 = store, 0 = load; sampled at grant.
REQ-011 SHALL have port d_addr, input, WIDTH: data address; sampled at grant.
REQ-012 SHALL have port d_wdata, input, WIDTH: store data; sampled at grant.
REQ-013 SHALL have port d_rdata, output, WIDTH: load result.
REQ-014 SHALL have port d_done, output, 1: one-cycle data-completion pulse.
REQ-015 SHALL have port mem_req, output, 1: access request to the shared single-port memory.
REQ-016 SHALL have ports mem_we (output, 1), mem_addr (output, WIDTH) and mem_wdata (output, WIDTH): memory command, write enable, address and write data.
REQ-017 SHALL have ports mem_rdata (input, WIDTH) and mem_ready (input, 1): read data, and access complete, valid only while mem_req=1.
REQ-018 SHALL have port busy, output, 1: high whenever the state is not IDLE.
REQ-019 SHALL have port err, output, 1: timeout flag, pulsed together with done.

Function
REQ-020 SHALL implement the states IDLE, IF_ACC, D_ACC and RESP.
REQ-021 SHALL, in IDLE with exactly one request high, grant that requester, register its address, write enable and write data, and go to the matching ACC state next cycle.
REQ-022 SHALL, in IDLE with both requests high, grant round-robin: the requester not in last_gnt wins; last_gnt resets to IF, so data wins the first tie.
REQ-023 SHALL update last_gnt at every grant.
REQ-024 SHALL, in an ACC state, drive mem_req=1 and drive mem_addr, mem_we and mem_wdata from the registered values, stable for the whole access; a fetch always drives mem_we=0.
REQ-025 SHALL, on mem_ready=1 in an ACC state, capture mem_rdata into if_rdata (fetch) or into d_rdata (load only), and go to RESP.
REQ-026 SHALL leave d_rdata unchanged on stores.
REQ-027 SHALL, in RESP, pulse if_done or d_done for exactly one cycle, matching the serviced requester, then go to IDLE.
REQ-028 SHALL hold if_rdata and d_rdata until their next capture.
REQ-029 SHALL keep mem_req=0 in IDLE and RESP.
REQ-030 SHALL achieve minimum latency: request seen in IDLE at cycle N, mem_req at N+1, mem_ready at N+1, done at N+2, next grant at N+3.
REQ-031 SHALL treat a request still high in the IDLE cycle after done as a new request; requesters deassert on the edge after done.
REQ-032 SHALL count ACC cycles with mem_ready=0 in a wait counter, cleared on entry to ACC.
REQ-033 SHALL, when the wait counter reaches TIMEOUT with no mem_ready, deassert mem_req, go to RESP, pulse done with err=1, and write 0 to the serviced rdata register; this applies to a store as well.
REQ-034 SHALL honour mem_ready on the same cycle the timeout would fire, completing normally with err=0.
REQ-035 SHALL ignore request changes during ACC and RESP; the registered command is used.
REQ-036 SHALL set busy = (state != IDLE).

Reset
REQ-037 SHALL, on rst low at any time including mid-access, asynchronously force state IDLE, last_gnt=IF, wait counter=0, and all outputs to 0.
REQ-038 SHALL abandon an access in flight at reset without a done pulse.
REQ-039 SHALL make the first grant possible on the first rising edge after rst goes high.

Verification
REQ-040 SHALL cover a lone fetch: if_req, if_addr=0x40, mem_ready one cycle after mem_req with mem_rdata=0x00500093 -> mem_addr=0x40, mem_we=0, if_rdata=0x00500093, if_done at cycle N+2.
REQ-041 SHALL cover a tie after reset: if_req and d_req together (d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF) -> the store is granted first with mem_we=1 and d_rdata unchanged, then the fetch is granted at the next IDLE.
REQ-042 SHALL cover sustained ties: both requests held high for four accesses -> grants alternate D, IF, D, IF.
REQ-043 SHALL cover a timeout: a load with mem_ready held low and TIMEOUT=16 -> mem_req drops after 16 cycles, then d_done=1, err=1 and d_rdata=0.
REQ-044 SHALL cover ready at the limit: mem_ready=1 on the 16th wait cycle with mem_rdata=0x1234 -> err=0 and d_rdata=0x1234.
REQ-045 SHALL cover reset mid-access: rst low during D_ACC -> mem_req=0 and busy=0 immediately, no d_done, and the state is IDLE after release.
